// File: rtl/instruction_memory_loader_if.sv
// instruction_memory_loader_if: word source / memory write-port bundle for the loader.
interface instruction_memory_loader_if #(parameter int CNT_W = 7);
  logic             inicio;
  logic [63:0]      base;
  logic             instr_valid;
  logic [31:0]      instr_in;
  logic             fin;
  logic             instr_ready;
  logic             mem_we;
  logic [63:0]      mem_direccion;
  logic [31:0]      mem_instruccion;
  logic             ocupado;
  logic             listo;
  logic             error;
  logic [CNT_W-1:0] palabras;
  modport master (
    output inicio, base, instr_valid, instr_in, fin,
    input  instr_ready, mem_we, mem_direccion, mem_instruccion, ocupado, listo, error, palabras
  );
  modport slave (
    input  inicio, base, instr_valid, instr_in, fin,
    output instr_ready, mem_we, mem_direccion, mem_instruccion, ocupado, listo, error, palabras
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader: streams instruction words into memory at consecutive word addresses.
module instruction_memory_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input logic                         clk,
  input logic                         reset,
  instruction_memory_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CARGA, FIN} state_t;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  state_t           state_q;
  logic [63:0]      base_q, dir_q;
  logic [31:0]      instr_q;
  logic [CNT_W-1:0] palabras_q, palabras_d;
  logic             we_q, error_q, ready, xfer;
  assign ready      = state_q == CARGA && palabras_q < DEPTH_C;
  assign xfer       = bus.instr_valid && ready;
  assign palabras_d = palabras_q + CNT_W'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      dir_q      <= '0;
      instr_q    <= '0;
      palabras_q <= '0;
      we_q       <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q <= xfer;
      if (xfer) begin
        dir_q      <= base_q + 64'({palabras_q, 2'b00});
        instr_q    <= bus.instr_in;
        palabras_q <= palabras_d;
      end
      case (state_q)
        IDLE:
          if (bus.inicio) begin
            if (bus.base[1:0] == 2'b00) begin
              base_q     <= bus.base;
              palabras_q <= '0;
              error_q    <= 1'b0;
              state_q    <= CARGA;
            end else error_q <= 1'b1;
          end
        // Filling to DEPTH without fin is a fault; an exact fill with fin is not.
        CARGA:
          if (xfer && (bus.fin || palabras_d == DEPTH_C)) begin
            state_q <= FIN;
            error_q <= !bus.fin;
          end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.instr_ready     = ready;
  assign bus.mem_we          = we_q;
  assign bus.mem_direccion   = dir_q;
  assign bus.mem_instruccion = instr_q;
  assign bus.ocupado         = state_q == CARGA;
  assign bus.listo           = state_q == FIN;
  assign bus.error           = error_q;
  assign bus.palabras        = palabras_q;
endmodule

// File: tb/tb_instruction_memory_loader.sv
// tb_instruction_memory_loader: directed checks of the loader with DEPTH=4.
module tb_instruction_memory_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  instruction_memory_loader_if #(.CNT_W(3)) bus ();
  instruction_memory_loader #(.DEPTH(4), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic f);
    bus.instr_valid = v;
    bus.instr_in    = d;
    bus.fin         = f;
  endtask
  task automatic start(input logic [63:0] b);
    bus.inicio = 1'b1;
    bus.base   = b;
    tick();
    bus.inicio = 1'b0;
  endtask
  task automatic chk_write(input string tag, input logic [63:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 64'(bus.mem_we), 64'd1);
    chk({tag, "_addr"}, bus.mem_direccion, a);
    chk({tag, "_data"}, 64'(bus.mem_instruccion), 64'(d));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, "_addr"}, bus.mem_direccion, 64'd0);
    chk({tag, "_data"}, 64'(bus.mem_instruccion), 64'd0);
    chk({tag, "_rdy"}, 64'(bus.instr_ready), 64'd0);
    chk({tag, "_ocup"}, 64'(bus.ocupado), 64'd0);
    chk({tag, "_listo"}, 64'(bus.listo), 64'd0);
    chk({tag, "_err"}, 64'(bus.error), 64'd0);
    chk({tag, "_pal"}, 64'(bus.palabras), 64'd0);
  endtask
  initial begin
    bus.inicio = 1'b0;
    bus.base   = '0;
    drive(1'b0, '0, 1'b0);
    #1 reset = 1'b1;
    #1 chk_zero("reset_async");
    tick();
    tick();
    reset = 1'b0;
    // basic three-word load, first inicio right after reset release
    start(64'h0);
    chk("t1_ocup", 64'(bus.ocupado), 64'd1);
    chk("t1_rdy", 64'(bus.instr_ready), 64'd1);
    chk("t1_pal0", 64'(bus.palabras), 64'd0);
    drive(1'b1, 32'h8B020020, 1'b0);
    tick();
    chk_write("t1_w0", 64'h0, 32'h8B020020);
    chk("t1_pal1", 64'(bus.palabras), 64'd1);
    drive(1'b1, 32'hCB030041, 1'b0);
    tick();
    chk_write("t1_w1", 64'h4, 32'hCB030041);
    drive(1'b1, 32'hF8400062, 1'b1);
    tick();
    chk_write("t1_w2", 64'h8, 32'hF8400062);
    chk("t1_listo", 64'(bus.listo), 64'd1);
    chk("t1_rdy_fin", 64'(bus.instr_ready), 64'd0);
    chk("t1_ocup_fin", 64'(bus.ocupado), 64'd0);
    chk("t1_pal3", 64'(bus.palabras), 64'd3);
    chk("t1_err", 64'(bus.error), 64'd0);
    drive(1'b0, '0, 1'b0);
    tick();
    chk("t1_we_idle", 64'(bus.mem_we), 64'd0);
    chk("t1_listo_off", 64'(bus.listo), 64'd0);
    chk("t1_addr_hold", bus.mem_direccion, 64'h8);
    chk("t1_data_hold", 64'(bus.mem_instruccion), 64'hF8400062);
    // gapped valid
    start(64'h100);
    drive(1'b1, 32'hA1, 1'b0);
    tick();
    chk_write("t2_w0", 64'h100, 32'hA1);
    drive(1'b0, 32'hDEAD, 1'b1);
    tick();
    chk("t2_gap0", 64'(bus.mem_we), 64'd0);
    chk("t2_gap0_pal", 64'(bus.palabras), 64'd1);
    drive(1'b1, 32'hA2, 1'b0);
    tick();
    chk_write("t2_w1", 64'h104, 32'hA2);
    drive(1'b0, 32'hBEEF, 1'b0);
    tick();
    chk("t2_gap1", 64'(bus.mem_we), 64'd0);
    drive(1'b1, 32'hA3, 1'b1);
    tick();
    chk_write("t2_w2", 64'h108, 32'hA3);
    chk("t2_listo", 64'(bus.listo), 64'd1);
    drive(1'b0, '0, 1'b0);
    tick();
    chk("t2_we_idle", 64'(bus.mem_we), 64'd0);
    // overflow: 6 words offered without fin, DEPTH=4
    start(64'h0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(k + 1), 1'b0);
      tick();
      chk_write($sformatf("t3_w%0d", k), 64'(4 * k), 32'(k + 1));
    end
    chk("t3_err", 64'(bus.error), 64'd1);
    chk("t3_listo", 64'(bus.listo), 64'd1);
    chk("t3_rdy", 64'(bus.instr_ready), 64'd0);
    chk("t3_pal", 64'(bus.palabras), 64'd4);
    drive(1'b1, 32'h5, 1'b0);
    tick();
    chk("t3_no_w5", 64'(bus.mem_we), 64'd0);
    drive(1'b1, 32'h6, 1'b0);
    tick();
    chk("t3_no_w6", 64'(bus.mem_we), 64'd0);
    chk("t3_pal_hold", 64'(bus.palabras), 64'd4);
    chk("t3_err_sticky", 64'(bus.error), 64'd1);
    drive(1'b0, '0, 1'b0);
    // misaligned base
    start(64'h102);
    chk("t4_err", 64'(bus.error), 64'd1);
    chk("t4_ocup", 64'(bus.ocupado), 64'd0);
    chk("t4_rdy", 64'(bus.instr_ready), 64'd0);
    chk("t4_we", 64'(bus.mem_we), 64'd0);
    chk("t4_pal", 64'(bus.palabras), 64'd4);
    start(64'h200);
    chk("t4_err_clr", 64'(bus.error), 64'd0);
    chk("t4_ocup2", 64'(bus.ocupado), 64'd1);
    chk("t4_pal0", 64'(bus.palabras), 64'd0);
    drive(1'b1, 32'h11, 1'b1);
    tick();
    chk_write("t4_w0", 64'h200, 32'h11);
    chk("t4_listo", 64'(bus.listo), 64'd1);
    drive(1'b0, '0, 1'b0);
    tick();
    // exact fill with fin on the last permitted word
    start(64'h300);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h70 + 32'(k), k == 3);
      tick();
      chk_write($sformatf("t5_w%0d", k), 64'h300 + 64'(4 * k), 32'h70 + 32'(k));
    end
    chk("t5_err", 64'(bus.error), 64'd0);
    chk("t5_listo", 64'(bus.listo), 64'd1);
    chk("t5_pal", 64'(bus.palabras), 64'd4);
    drive(1'b0, '0, 1'b0);
    tick();
    // reset mid-load
    start(64'h40);
    drive(1'b1, 32'h21, 1'b0);
    tick();
    chk_write("t6_w0", 64'h40, 32'h21);
    drive(1'b1, 32'h22, 1'b0);
    tick();
    chk_write("t6_w1", 64'h44, 32'h22);
    drive(1'b1, 32'h23, 1'b0);
    reset = 1'b1;
    #1 chk_zero("t6_rst");
    tick();
    chk("t6_rst_we", 64'(bus.mem_we), 64'd0);
    reset = 1'b0;
    tick();
    chk("t6_post_we", 64'(bus.mem_we), 64'd0);
    chk("t6_post_rdy", 64'(bus.instr_ready), 64'd0);
    drive(1'b0, '0, 1'b0);
    start(64'h0);
    drive(1'b1, 32'h31, 1'b1);
    tick();
    chk_write("t6_new", 64'h0, 32'h31);
    chk("t6_new_pal", 64'(bus.palabras), 64'd1);
    drive(1'b0, '0, 1'b0);
    tick();
    // address wrap
    start(64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 32'h41, 1'b0);
    tick();
    chk_write("t7_w0", 64'hFFFF_FFFF_FFFF_FFFC, 32'h41);
    drive(1'b1, 32'h42, 1'b1);
    tick();
    chk_write("t7_w1", 64'h0, 32'h42);
    chk("t7_err", 64'(bus.error), 64'd0);
    chk("t7_listo", 64'(bus.listo), 64'd1);
    drive(1'b0, '0, 1'b0);
    tick();
    chk("t7_we_idle", 64'(bus.mem_we), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
